clk_div_mon: RTL

CLK_DIV_MON -- requirements
Module: clk_div_mon

---
 rtl/clk_div_mon.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/clk_div_mon.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module : clk_div_mon                                                     |
// | Brief  : Divided-clock monitor. Synchronises CLK_DIV, strobes each edge, |
// |          measures half-periods and tracks lock/fault.                    |
// |          Optional statistics outputs: define CLK_DIV_MON_STATS_EN.       |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module clk_div_mon #(
    parameter int HALF_PER = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic       CLKD,
    input  logic       RSTN,
    input  logic       CLK_DIV,
    input  logic       ERR_CLR,
    output logic       DIV_STB,
    output logic       LOCK,
    output logic       ERR,
`ifdef CLK_DIV_MON_STATS_EN
    output logic [1:0] STATE,
    output logic [4:0] PER_MEAS,
    output logic [7:0] FAULT_CNT
`else
    output logic [1:0] STATE
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    localparam logic [4:0] C_CNT_MAX  = 5'd31;
    localparam logic [4:0] C_HALF     = 5'(HALF_PER);
    localparam logic [4:0] C_TMO_LAST = 5'(HALF_PER + 1);
    localparam logic [3:0] C_LOCK_TGT = 4'(LOCK_CNT);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_hist;
    logic       r_stb;
    logic       w_edge;
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_nxt;
    logic       w_good_meas;
    logic [3:0] r_good;
    logic [3:0] w_good_nxt;
    logic [3:0] w_good_inc;
    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_lock;
    logic       r_err;

    assign w_edge = r_sync2 ^ r_hist;

    always_ff @(posedge CLKD or negedge RSTN) begin
        if (!RSTN) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            r_sync1 <= CLK_DIV;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_stb   <= w_edge;
        end
    end

    // Counter restarts at 1 after a strobe so the value seen with the next strobe is the interval.
    assign w_cnt_nxt   = r_stb ? 5'd1 : ((r_cnt == C_CNT_MAX) ? C_CNT_MAX : r_cnt + 5'd1);
    assign w_good_meas = r_stb && (r_cnt == C_HALF);
    assign w_good_inc  = r_good + 4'd1;

    always_ff @(posedge CLKD or negedge RSTN) begin
        if (!RSTN) begin
            r_cnt <= 5'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        case (r_state)
            S_IDLE: begin
                if (r_stb) begin
                    w_state_nxt = S_ACQ;
                    w_good_nxt  = 4'd0;
                end
            end
            S_ACQ: begin
                if (r_stb) begin
                    if (w_good_meas) begin
                        if (w_good_inc == C_LOCK_TGT) begin
                            w_state_nxt = S_LOCKED;
                            w_good_nxt  = 4'd0;
                        end else begin
                            w_good_nxt  = w_good_inc;
                        end
                    end else begin
                        w_good_nxt = 4'd0;
                    end
                end else if (w_cnt_nxt == C_CNT_MAX) begin
                    w_state_nxt = S_IDLE;
                    w_good_nxt  = 4'd0;
                end
            end
            S_LOCKED: begin
                // Timeout fires on the clock where the counter would reach HALF_PER+2.
                if ((r_stb && !w_good_meas) || (!r_stb && (r_cnt == C_TMO_LAST))) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_FAULT: begin
                if (ERR_CLR) begin
                    w_state_nxt = S_IDLE;
                    w_good_nxt  = 4'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_good_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLKD or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
            r_good  <= 4'd0;
            r_lock  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
            r_lock  <= (w_state_nxt == S_LOCKED);
            r_err   <= (w_state_nxt == S_FAULT);
        end
    end

    assign DIV_STB = r_stb;
    assign LOCK    = r_lock;
    assign ERR     = r_err;
    assign STATE   = r_state;

`ifdef CLK_DIV_MON_STATS_EN
    logic [4:0] r_per_meas;
    logic [7:0] r_fault_cnt;
    logic       w_meas_vld;
    logic       w_fault_entry;

    assign w_meas_vld    = r_stb && ((r_state == S_ACQ) || (r_state == S_LOCKED));
    assign w_fault_entry = (w_state_nxt == S_FAULT) && (r_state != S_FAULT);

    always_ff @(posedge CLKD or negedge RSTN) begin
        if (!RSTN) begin
            r_per_meas  <= 5'd0;
            r_fault_cnt <= 8'd0;
        end else begin
            if (w_meas_vld) begin
                r_per_meas <= r_cnt;
            end
            if (w_fault_entry && (r_fault_cnt != 8'hFF)) begin
                r_fault_cnt <= r_fault_cnt + 8'd1;
            end
        end
    end

    assign PER_MEAS  = r_per_meas;
    assign FAULT_CNT = r_fault_cnt;
`endif

endmodule
`default_nettype wire
